// File: rtl/rom_dump_streamer_pkg.sv
// Shared definitions for the ROM dump streamer: FSM state encoding, chip geometry
// and the baud divisor helper used by the UART.
package rom_dump_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    typedef enum logic {
        CHIP_IP3601 = 1'b0,
        CHIP_IP3604 = 1'b1
    } chip_e;

    localparam int IP3601_ADDRESS_WIDTH = 8;
    localparam int IP3601_DATA_WIDTH    = 4;
    localparam int IP3604_ADDRESS_WIDTH = 9;
    localparam int IP3604_DATA_WIDTH    = 8;

    // Cycles per UART bit, rounded down.
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int chip_address_width(input chip_e chip);
        return (chip == CHIP_IP3604) ? IP3604_ADDRESS_WIDTH : IP3601_ADDRESS_WIDTH;
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter, LSB first. Accepts a byte only while idle; tx_busy rises the
// cycle after tx_start and falls at the end of the stop bit.
module uart_tx_8n1
    import rom_dump_streamer_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] baud_cnt_q;
    logic [3:0]    bit_cnt_q;
    logic [9:0]    frame_q;
    logic          busy_q;
    logic          tx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '1;
            busy_q     <= 1'b0;
            tx_q       <= 1'b1;
        end else if (!busy_q) begin
            if (tx_start) begin
                // Frame is {stop, data, start}; bit 0 goes on the line immediately.
                frame_q    <= {1'b1, tx_data, 1'b0};
                tx_q       <= 1'b0;
                busy_q     <= 1'b1;
                baud_cnt_q <= '0;
                bit_cnt_q  <= '0;
            end
        end else if (baud_cnt_q == CW'(BAUD_DIV - 1)) begin
            baud_cnt_q <= '0;
            if (bit_cnt_q == 4'd9) begin
                busy_q <= 1'b0;
                tx_q   <= 1'b1;
            end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
                frame_q   <= {1'b1, frame_q[9:1]};
                tx_q      <= frame_q[1];
            end
        end else begin
            baud_cnt_q <= baud_cnt_q + CW'(1);
        end
    end

    assign tx_busy = busy_q;
    assign tx      = tx_q;

endmodule

// File: rtl/rom_dump_streamer.sv
// Sweeps every ROM address, samples each word after a settle delay and streams it
// as one raw byte over the UART, in address order.
module rom_dump_streamer
    import rom_dump_streamer_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD          = 115200,
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [DATA_WIDTH-1:0]    chip_data_port,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic                     chip_enable,
    output logic                     uart_tx,
    output logic                     busy,
    output logic                     done
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

    state_e                   state_q;
    logic                     start_q;
    logic [SW-1:0]            settle_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     ce_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     tx_start_q;
    logic [7:0]               byte_q;
    logic [7:0]               sample_d;
    logic                     tx_busy;
    logic                     start_rise;

    always_comb begin
        sample_d                 = '0;
        sample_d[DATA_WIDTH-1:0] = chip_data_port;
    end

    assign start_rise = start & ~start_q;

    // Tracks start even through reset so a request held across reset is not a new edge.
    always_ff @(posedge clk) begin
        start_q <= start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            settle_q   <= '0;
            addr_q     <= '0;
            ce_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_start_q <= 1'b0;
            byte_q     <= '0;
        end else begin
            done_q     <= 1'b0;
            tx_start_q <= 1'b0;
            if (abort && state_q != ST_IDLE) begin
                state_q <= ST_IDLE;
                addr_q  <= '0;
                ce_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_rise) begin
                            state_q  <= ST_SETTLE;
                            addr_q   <= '0;
                            settle_q <= '0;
                            ce_q     <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                            state_q <= ST_SAMPLE;
                        end else begin
                            settle_q <= settle_q + SW'(1);
                        end
                    end
                    ST_SAMPLE: begin
                        byte_q  <= sample_d;
                        state_q <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (!tx_busy) begin
                            tx_start_q <= 1'b1;
                            state_q    <= ST_WAIT_TX;
                        end
                    end
                    ST_WAIT_TX: begin
                        // Once the byte is taken, the next address settles during its frame.
                        if (tx_busy) begin
                            if (addr_q == LAST_ADDR) begin
                                state_q <= ST_DRAIN;
                            end else begin
                                addr_q   <= addr_q + ADDRESS_WIDTH'(1);
                                settle_q <= '0;
                                state_q  <= ST_SETTLE;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (!tx_busy) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ce_q    <= 1'b0;
                            addr_q  <= '0;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    uart_tx_8n1 #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_uart (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start_q),
        .tx_data  (byte_q),
        .tx_busy  (tx_busy),
        .tx       (uart_tx)
    );

    assign address_line = addr_q;
    assign chip_enable  = ce_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_rom_dump_streamer.sv
// Directed bench for rom_dump_streamer: a UART decoder rebuilds the byte stream and
// compares it with the expected ROM image; a per-cycle process checks handshake outputs.
`timescale 1ns/1ps
module tb_rom_dump_streamer;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int BDIV     = 10;
    localparam int AW       = 2;
    localparam int SC       = 4;
    localparam int NBYTES   = 1 << AW;
    localparam int FRAME    = 10 * BDIV;

    logic          clk = 1'b0;
    logic          reset;
    logic          start8, start4, abort8, abort4;
    logic [AW-1:0] addr8, addr4;
    logic          ce8, ce4, tx8, tx4, busy8, busy4, done8, done4;
    logic [7:0]    chip8;
    logic [3:0]    chip4;

    logic          sel;
    logic          mon_tx, mon_busy, mon_ce, mon_done;
    logic [AW-1:0] mon_addr;

    int total = 0;
    int bad   = 0;

    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    int         exp_len = NBYTES;
    int         done_cnt = 0;
    int         frame_start_cnt = 0;
    bit         dec_active = 0;
    int         dec_cnt = 0;
    logic       prev_done = 1'b0;

    always #5 clk = ~clk;

    assign chip8 = 8'hA0 | {6'b0, addr8};
    assign chip4 = 4'h5;

    assign mon_tx   = sel ? tx4   : tx8;
    assign mon_busy = sel ? busy4 : busy8;
    assign mon_ce   = sel ? ce4   : ce8;
    assign mon_done = sel ? done4 : done8;
    assign mon_addr = sel ? addr4 : addr8;

    rom_dump_streamer #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDRESS_WIDTH(AW), .DATA_WIDTH(8), .SETTLE_CYCLES(SC)
    ) dut8 (
        .clk(clk), .reset(reset), .start(start8), .abort(abort8), .chip_data_port(chip8),
        .address_line(addr8), .chip_enable(ce8), .uart_tx(tx8), .busy(busy8), .done(done8)
    );

    rom_dump_streamer #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDRESS_WIDTH(AW), .DATA_WIDTH(4), .SETTLE_CYCLES(SC)
    ) dut4 (
        .clk(clk), .reset(reset), .start(start4), .abort(abort4), .chip_data_port(chip4),
        .address_line(addr4), .chip_enable(ce4), .uart_tx(tx4), .busy(busy4), .done(done4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        end
    endtask

    // Expected dump image: byte k is the ROM word at address k, zero-extended.
    task automatic build_exp(input bit narrow, input int n);
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            if (narrow) exp_q.push_back(8'h05);
            else        exp_q.push_back(8'hA0 | 8'(k));
        end
    endtask

    task automatic cmp_bytes(input string name);
        chk({name, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", name, i), cap_q[i], exp_q[i]);
        end
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int n = 0;
        while (!mon_done && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, mon_done, 1'b1);
    endtask

    task automatic pulse_start8();
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // UART decoder: one frame is FRAME cycles starting at the first low sample.
    initial begin : decoder
        logic [FRAME-1:0] smp;
        logic [7:0]       d;
        bit               ok;
        smp = '1;
        forever begin
            @(negedge clk);
            if (reset) begin
                dec_active = 0;
            end else if (!dec_active) begin
                if (mon_tx == 1'b0) begin
                    dec_active = 1;
                    smp[0]     = 1'b0;
                    dec_cnt    = 1;
                    frame_start_cnt++;
                end
            end else begin
                smp[dec_cnt] = mon_tx;
                dec_cnt++;
                if (dec_cnt == FRAME) begin
                    dec_active = 0;
                    ok = 1;
                    for (int b = 0; b < 10; b++)
                        for (int j = 1; j < BDIV; j++)
                            if (smp[b*BDIV + j] !== smp[b*BDIV]) ok = 0;
                    chk("bit_width_stable", ok, 1'b1);
                    chk("stop_bit", smp[9*BDIV + BDIV/2], 1'b1);
                    for (int b = 0; b < 8; b++) d[b] = smp[(b+1)*BDIV + BDIV/2];
                    cap_q.push_back(d);
                end
            end
        end
    end

    // Per-cycle checks on the handshake outputs of the selected instance.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("ce_tracks_busy", mon_ce, mon_busy);
                if (!mon_busy) chk("addr_zero_when_idle", mon_addr, '0);
                if (mon_done) begin
                    done_cnt++;
                    chk("done_busy_low", mon_busy, 1'b0);
                    chk("done_after_last_byte", cap_q.size(), exp_len);
                    chk("done_one_cycle", prev_done, 1'b0);
                end
                prev_done = mon_done;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d0;
        int n;
        bit all_high;
        int fs0;

        reset = 1'b1; start8 = 1'b1; start4 = 1'b0; abort8 = 1'b0; abort4 = 1'b0; sel = 1'b0;

        // 1: reset with start held high
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_uart_tx", mon_tx, 1'b1);
        chk("rst_busy", mon_busy, 1'b0);
        chk("rst_done", mon_done, 1'b0);
        chk("rst_addr", mon_addr, 2'd0);
        chk("rst_ce", mon_ce, 1'b0);
        repeat (20) @(negedge clk);
        chk("held_start_no_dump", mon_busy, 1'b0);
        chk("held_start_no_frame", frame_start_cnt, 0);
        start8 = 1'b0;
        @(negedge clk);

        // 2: single start pulse, full dump
        cap_q.delete(); build_exp(0, NBYTES); d0 = done_cnt;
        start8 = 1'b1;
        @(negedge clk);
        chk("busy_latency", mon_busy, 1'b1);
        start8 = 1'b0;
        wait_done("t2", 2000);
        @(negedge clk);
        chk("t2_busy_after_done", mon_busy, 1'b0);
        repeat (20) @(negedge clk);
        cmp_bytes("t2");
        chk("t2_first_byte_literal", cap_q.size() > 0 ? cap_q[0] : 8'hxx, 8'hA0);
        chk("t2_last_byte_literal", cap_q.size() > 3 ? cap_q[3] : 8'hxx, 8'hA3);
        chk("t2_done_count", done_cnt - d0, 1);

        // 3: start held high with extra pulses while busy
        cap_q.delete(); d0 = done_cnt;
        start8 = 1'b1;
        repeat (50) @(negedge clk);
        start8 = 1'b0; repeat (2) @(negedge clk); start8 = 1'b1;
        repeat (100) @(negedge clk);
        start8 = 1'b0; repeat (2) @(negedge clk); start8 = 1'b1;
        wait_done("t3", 2000);
        repeat (150) @(negedge clk);
        cmp_bytes("t3");
        chk("t3_done_count", done_cnt - d0, 1);
        chk("t3_no_retrigger", mon_busy, 1'b0);
        start8 = 1'b0;
        @(negedge clk);

        // 4: abort while address 2 settles
        cap_q.delete(); d0 = done_cnt;
        pulse_start8();
        n = 0;
        while (!(mon_busy && mon_addr == 2'd2) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t4_reached_addr2", mon_addr, 2'd2);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        chk("t4_abort_busy", mon_busy, 1'b0);
        chk("t4_abort_addr", mon_addr, 2'd0);
        repeat (300) @(negedge clk);
        build_exp(0, 2);
        cmp_bytes("t4");
        chk("t4_inflight_literal", cap_q.size() > 1 ? cap_q[1] : 8'hxx, 8'hA1);
        chk("t4_no_done", done_cnt - d0, 0);
        cap_q.delete(); build_exp(0, NBYTES); d0 = done_cnt;
        pulse_start8();
        wait_done("t4b", 2000);
        repeat (20) @(negedge clk);
        cmp_bytes("t4b");
        chk("t4b_done_count", done_cnt - d0, 1);

        // 5: reset during the start bit of the second byte
        cap_q.delete();
        pulse_start8();
        n = 0;
        while (!(cap_q.size() == 1 && dec_active && dec_cnt >= 3 && dec_cnt <= 6) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_mid_start_bit", dec_active, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_tx_high_next", mon_tx, 1'b1);
        reset = 1'b0;
        fs0 = frame_start_cnt;
        all_high = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mon_tx !== 1'b1) all_high = 0;
        end
        chk("t5_tx_stays_high", all_high, 1'b1);
        chk("t5_busy", mon_busy, 1'b0);
        chk("t5_no_frames", frame_start_cnt - fs0, 0);
        chk("t5_bytes_before_reset", cap_q.size(), 1);

        // 6: 4-bit data instance
        sel = 1'b1;
        @(negedge clk);
        cap_q.delete(); build_exp(1, NBYTES); d0 = done_cnt;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done("t6", 2000);
        repeat (20) @(negedge clk);
        cmp_bytes("t6");
        chk("t6_byte0_literal", cap_q.size() > 0 ? cap_q[0] : 8'hxx, 8'h05);
        chk("t6_byte2_literal", cap_q.size() > 2 ? cap_q[2] : 8'hxx, 8'h05);
        chk("t6_done_count", done_cnt - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
